// File: rtl/rcosc_reset_sequencer.sv
// Power-up reset sequencer for the RC-oscillator fabric clock domain.
// Waits for oscillator settling, qualifies PLL lock, then releases the
// MSS, fabric and core resets in order. Lock loss or a soft-reset request
// pulls every domain back into reset and restarts qualification.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_STARTUP   | oscillator settling, lock and soft reset ignored
// ST_WAIT_LOCK | counting consecutive synced-high lock samples
// ST_REL_MSS   | MSS released, waiting one release gap
// ST_REL_FAB   | MSS and fabric released, waiting one release gap
// ST_RUN       | all domains released, READY high
// ST_HOLD      | soft reset in progress, all domains held for at least one gap
`timescale 1ns/1ps

module rcosc_reset_sequencer #(
  parameter int unsigned STARTUP_CYCLES = 1024,
  parameter int unsigned LOCK_FILTER    = 16,
  parameter int unsigned RELEASE_GAP    = 8
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic PLL_LOCK,
  input  logic SOFT_RESET_REQ,
  input  logic LOST_CLR,
  output logic MSS_RESETN,
  output logic FAB_RESETN,
  output logic CORE_RESETN,
  output logic READY,
  output logic LOCK_LOST
);

  localparam logic [15:0] STARTUP_LAST = 16'(STARTUP_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST    = 16'(LOCK_FILTER - 1);
  localparam logic [15:0] GAP_LAST     = 16'(RELEASE_GAP - 1);
  localparam logic [15:0] GAP          = 16'(RELEASE_GAP);

  typedef enum logic [2:0] {
    ST_STARTUP   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_REL_MSS   = 3'd2,
    ST_REL_FAB   = 3'd3,
    ST_RUN       = 3'd4,
    ST_HOLD      = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        lock_meta, lock_sync;
  logic        lost_set;
  logic        mss_nxt, fab_nxt, core_nxt;

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= PLL_LOCK;
      lock_sync <= lock_meta;
    end
  end

  // State and shared counter registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= ST_STARTUP;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and counter logic; the counter restarts on every transition.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 16'd1;
    lost_set  = 1'b0;
    case (state)
      ST_STARTUP: begin
        if (cnt == STARTUP_LAST) state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_sync && !SOFT_RESET_REQ) begin
          if (cnt == LOCK_LAST) state_nxt = ST_REL_MSS;
        end else begin
          cnt_nxt = '0;
        end
      end
      ST_REL_MSS, ST_REL_FAB, ST_RUN: begin
        // Lock loss outranks a simultaneous soft-reset request.
        if (!lock_sync) begin
          state_nxt = ST_WAIT_LOCK;
          lost_set  = 1'b1;
        end else if (SOFT_RESET_REQ) begin
          state_nxt = ST_HOLD;
        end else if (state == ST_RUN) begin
          cnt_nxt = cnt;
        end else if (cnt == GAP_LAST) begin
          state_nxt = (state == ST_REL_MSS) ? ST_REL_FAB : ST_RUN;
        end
      end
      ST_HOLD: begin
        if (!lock_sync) lost_set = 1'b1;
        if (cnt >= GAP) begin
          cnt_nxt = cnt;
          if (!SOFT_RESET_REQ) state_nxt = ST_WAIT_LOCK;
        end
      end
      default: state_nxt = ST_STARTUP;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

  // Output decode from the next state so outputs move with the state flop.
  always_comb begin
    mss_nxt  = (state_nxt == ST_REL_MSS) || (state_nxt == ST_REL_FAB) || (state_nxt == ST_RUN);
    fab_nxt  = (state_nxt == ST_REL_FAB) || (state_nxt == ST_RUN);
    core_nxt = (state_nxt == ST_RUN);
  end

  // Registered outputs; a new lock loss wins over a same-cycle clear.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      MSS_RESETN  <= 1'b0;
      FAB_RESETN  <= 1'b0;
      CORE_RESETN <= 1'b0;
      READY       <= 1'b0;
      LOCK_LOST   <= 1'b0;
    end else begin
      MSS_RESETN  <= mss_nxt;
      FAB_RESETN  <= fab_nxt;
      CORE_RESETN <= core_nxt;
      READY       <= core_nxt;
      if (lost_set)      LOCK_LOST <= 1'b1;
      else if (LOST_CLR) LOCK_LOST <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rcosc_reset_sequencer.sv
// Directed bench for rcosc_reset_sequencer with a per-edge expectation queue.
`timescale 1ns/1ps

module tb_rcosc_reset_sequencer;

  logic CLK = 1'b0;
  logic RESETN, PLL_LOCK, SOFT_RESET_REQ, LOST_CLR;
  logic MSS_RESETN, FAB_RESETN, CORE_RESETN, READY, LOCK_LOST;
  logic [4:0] obs;

  typedef struct {
    string      tag;
    logic [4:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic chat_pat [8];

  // {MSS, FAB, CORE, READY, LOCK_LOST}
  localparam logic [4:0] O_0 = 5'b00000;
  localparam logic [4:0] O_M = 5'b10000;
  localparam logic [4:0] O_F = 5'b11000;
  localparam logic [4:0] O_R = 5'b11110;
  localparam logic [4:0] L   = 5'b00001;

  rcosc_reset_sequencer #(
    .STARTUP_CYCLES(16),
    .LOCK_FILTER   (4),
    .RELEASE_GAP   (3)
  ) dut (
    .CLK           (CLK),
    .RESETN        (RESETN),
    .PLL_LOCK      (PLL_LOCK),
    .SOFT_RESET_REQ(SOFT_RESET_REQ),
    .LOST_CLR      (LOST_CLR),
    .MSS_RESETN    (MSS_RESETN),
    .FAB_RESETN    (FAB_RESETN),
    .CORE_RESETN   (CORE_RESETN),
    .READY         (READY),
    .LOCK_LOST     (LOCK_LOST)
  );

  assign obs = {MSS_RESETN, FAB_RESETN, CORE_RESETN, READY, LOCK_LOST};

  always #10 CLK = ~CLK;

  task automatic push(input string tag, input int n, input logic [4:0] v);
    for (int i = 0; i < n; i++) sb_q.push_back('{tag, v});
  endtask

  task automatic check_item();
    exp_t it;
    it = sb_q.pop_front();
    n_tests++;
    assert (obs === it.exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", it.tag, obs, it.exp);
    end
  endtask

  // One queued expectation per clock edge, sampled 1 ns after the edge.
  task automatic drain();
    while (sb_q.size() > 0) begin
      @(posedge CLK);
      #1;
      check_item();
    end
  endtask

  task automatic expect_release(input string tag, input logic [4:0] lost, input int n_run);
    push({tag, "_mss"}, 3, O_M | lost);
    push({tag, "_fab"}, 3, O_F | lost);
    push({tag, "_run"}, n_run, O_R | lost);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    RESETN = 1'b0; PLL_LOCK = 1'b1; SOFT_RESET_REQ = 1'b0; LOST_CLR = 1'b0;
    chat_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    #5;
    push("reset", 1, O_0); check_item();
    #40;
    RESETN = 1'b1;

    // Power-up with lock tied high: MSS at edge 20, FAB 23, RUN 26.
    push("pwr_startup", 19, O_0);
    expect_release("pwr", O_0, 3);
    drain();

    // One-cycle lock drop in RUN, then re-lock and clear.
    PLL_LOCK = 1'b0;
    push("loss_pre", 1, O_R); drain();
    PLL_LOCK = 1'b1;
    push("loss_pre", 1, O_R);
    push("loss_drop", 4, L);
    expect_release("loss", L, 2);
    drain();
    LOST_CLR = 1'b1;
    push("lost_clr", 1, O_R); drain();
    LOST_CLR = 1'b0;
    push("lost_clr_hold", 2, O_R); drain();

    // Soft reset for one cycle: HOLD 3 edges, then WAIT_LOCK.
    SOFT_RESET_REQ = 1'b1;
    push("soft1_drop", 1, O_0); drain();
    SOFT_RESET_REQ = 1'b0;
    push("soft1_hold_wait", 7, O_0);
    expect_release("soft1", O_0, 2);
    drain();

    // Soft reset held 10 cycles: HOLD persists until the request drops.
    SOFT_RESET_REQ = 1'b1;
    push("soft10_hold", 10, O_0); drain();
    SOFT_RESET_REQ = 1'b0;
    push("soft10_wait", 4, O_0);
    expect_release("soft10", O_0, 2);
    drain();

    // Lock held low into WAIT_LOCK, then chatter 1,1,1,0,1,1,1,1.
    PLL_LOCK = 1'b0;
    push("chat_pre", 2, O_R);
    push("chat_drop", 3, L);
    drain();
    for (int i = 0; i < 8; i++) begin
      PLL_LOCK = chat_pat[i];
      push("chat_wait", 1, L); drain();
    end
    push("chat_wait", 1, L);
    expect_release("chat", L, 2);
    drain();

    // Lock loss and soft reset seen on the same edge.
    LOST_CLR = 1'b1;
    push("clr2", 1, O_R); drain();
    LOST_CLR = 1'b0;
    PLL_LOCK = 1'b0;
    push("sim_pre", 1, O_R); drain();
    PLL_LOCK = 1'b1;
    push("sim_pre", 1, O_R); drain();
    SOFT_RESET_REQ = 1'b1;
    push("sim_soft_loss", 1, L); drain();
    SOFT_RESET_REQ = 1'b0;
    push("sim_wait", 3, L);
    expect_release("sim", L, 2);
    drain();

    // LOST_CLR and a fresh lock loss on the same edge.
    PLL_LOCK = 1'b0;
    push("clrloss_pre", 1, O_R | L); drain();
    PLL_LOCK = 1'b1;
    push("clrloss_pre", 1, O_R | L); drain();
    LOST_CLR = 1'b1;
    push("clr_vs_loss", 1, L); drain();
    LOST_CLR = 1'b0;
    push("clrloss_wait", 3, L);
    push("clrloss_mss", 3, O_M | L);
    push("clrloss_fab", 1, O_F | L);
    drain();

    // Async reset while in REL_FAB, then full restart.
    #5;
    RESETN = 1'b0;
    #1;
    push("async_rst", 1, O_0); check_item();
    #5;
    RESETN = 1'b1;
    push("restart_startup", 19, O_0);
    expect_release("restart", O_0, 3);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
